// File: rtl/sms_bus_pkg.sv
// Shared definitions for the SMS core data-bus responder.
// Contents: FSM state encoding, address region bounds, mapper bank reset values,
// the open-bus read value and the request-qualifier decode helper.
package sms_bus_pkg;

  // Responder FSM states. RAM accesses and ignored ROM writes complete straight
  // from IDLE, so only the handshake states need their own encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROM  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam logic [15:0] ROM_END     = 16'hBFFF;
  localparam logic [15:0] RAM_BASE    = 16'hC000;
  localparam logic [15:0] MAPPER_BASE = 16'hFFFC;
  // The first 1KB of the memory map is never paged.
  localparam logic [15:0] UNPAGED_END = 16'h03FF;

  localparam logic [7:0] BANK0_RST = 8'd0;
  localparam logic [7:0] BANK1_RST = 8'd1;
  localparam logic [7:0] BANK2_RST = 8'd2;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // A request needs exactly one space qualifier and exactly one direction.
  function automatic logic req_valid(input logic mreq, input logic iorq,
                                     input logic rd, input logic wr);
    return (mreq ^ iorq) & (rd ^ wr);
  endfunction

endpackage

// File: rtl/sega_mapper.sv
// Sega-style ROM mapper: paging registers at FFFC-FFFF and the combinational
// CPU-address to physical-ROM-address translation.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   we         write strobe for a completed write into FFFC-FFFF
//   addr       16-bit CPU address (register select on writes, translated on reads)
//   wdata      register write data
//   rom_addr   22-bit physical ROM byte address for addr
module sega_mapper
  import sms_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [21:0] rom_addr
);

  logic [7:0] ctrl;
  logic [7:0] bank0;
  logic [7:0] bank1;
  logic [7:0] bank2;
  logic [7:0] bank_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= 8'h00;
      bank0 <= BANK0_RST;
      bank1 <= BANK1_RST;
      bank2 <= BANK2_RST;
    end else if (we) begin
      case (addr[1:0])
        2'd0:    ctrl  <= wdata;
        2'd1:    bank0 <= wdata;
        2'd2:    bank1 <= wdata;
        default: bank2 <= wdata;
      endcase
    end
  end

  always_comb begin
    case (addr[15:14])
      2'd0:    bank_sel = bank0;
      2'd1:    bank_sel = bank1;
      default: bank_sel = bank2;
    endcase
    if (addr <= UNPAGED_END) begin
      rom_addr = {6'd0, addr};
    end else begin
      rom_addr = {bank_sel, addr[13:0]};
    end
  end

endmodule

// File: rtl/sms_bus_responder.sv
// Target side of the core data-memory bus. Decodes each core request and answers
// it from internal work RAM (C000-FFFF, mirrored), from ROM through a req/ack
// port (0000-BFFF) or from I/O through a strobe/ack port, holding D_wait high
// until the answer is ready. Handshakes that stall longer than TIMEOUT cycles
// are force-completed with open-bus data and flag the sticky bus_err.
// Optional build macro SEGA_MAPPER_EN adds the Sega paging registers at
// FFFC-FFFF; without it ROM addresses pass through unpaged.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   D_addr, D_data_out        core address / write data
//   MREQ, IORQ, RD, WR        core request qualifiers
//   D_data_in, D_wait         read data (valid when D_wait falls) / stall
//   rom_addr, rom_req         ROM address and request, held until rom_ack
//   rom_ack, rom_data         ROM completion and read data
//   io_addr, io_wdata         I/O port and write data
//   io_rd, io_wr              I/O strobes, held until io_ack
//   io_ack, io_rdata          I/O completion and read data
//   bus_err                   sticky handshake-timeout flag
module sms_bus_responder
  import sms_bus_pkg::*;
#(
  parameter int unsigned RAM_AW  = 13,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] D_addr,
  input  logic [7:0]  D_data_out,
  output logic [7:0]  D_data_in,
  input  logic        MREQ,
  input  logic        IORQ,
  input  logic        RD,
  input  logic        WR,
  output logic        D_wait,
  output logic [21:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [7:0]        wait_cnt;
  logic              io_is_rd;
  logic              valid;
  logic              ram_sel;
  logic              ram_we;
  logic              timed_out;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        ram_rdata;
  logic [21:0]       rom_addr_map;
  logic [7:0]        ram [RAM_DEPTH];

  assign valid     = req_valid(MREQ, IORQ, RD, WR);
  assign ram_sel   = MREQ & (D_addr >= RAM_BASE);
  assign ram_idx   = D_addr[RAM_AW-1:0];
  assign ram_rdata = ram[ram_idx];
  assign timed_out = (wait_cnt == TO_LAST);

  // RST gates the write so a write pending at reset never lands in the array.
  assign ram_we = (state == ST_IDLE) & valid & ram_sel & WR & ~RST;

  assign D_wait  = valid & (state != ST_ACK) & ~RST;
  assign rom_req = (state == ST_ROM);
  assign io_rd   = (state == ST_IO) & io_is_rd;
  assign io_wr   = (state == ST_IO) & ~io_is_rd;

`ifdef SEGA_MAPPER_EN
  logic map_we;

  assign map_we = ram_we & (D_addr >= MAPPER_BASE);

  sega_mapper u_mapper (
    .clk      (CLK),
    .rst      (RST),
    .we       (map_we),
    .addr     (D_addr),
    .wdata    (D_data_out),
    .rom_addr (rom_addr_map)
  );
`else
  assign rom_addr_map = {6'd0, D_addr};
`endif

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_idx] <= D_data_out;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      io_is_rd  <= 1'b0;
      rom_addr  <= 22'd0;
      io_addr   <= 8'd0;
      io_wdata  <= 8'd0;
      D_data_in <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            wait_cnt <= 8'd0;
            if (IORQ) begin
              state    <= ST_IO;
              io_addr  <= D_addr[7:0];
              io_wdata <= D_data_out;
              io_is_rd <= RD;
            end else if (ram_sel) begin
              // RAM completes from the decode cycle: one wait cycle.
              state <= ST_ACK;
              if (RD) begin
                D_data_in <= ram_rdata;
              end
            end else if (RD && D_addr <= ROM_END) begin
              state    <= ST_ROM;
              rom_addr <= rom_addr_map;
            end else begin
              // ROM writes are accepted and dropped.
              state <= ST_ACK;
            end
          end
        end
        ST_ROM: begin
          // An ack in the timeout cycle still wins.
          if (rom_ack) begin
            D_data_in <= rom_data;
            state     <= ST_ACK;
          end else if (timed_out) begin
            D_data_in <= OPEN_BUS;
            bus_err   <= 1'b1;
            state     <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_IO: begin
          if (io_ack) begin
            if (io_is_rd) begin
              D_data_in <= io_rdata;
            end
            state <= ST_ACK;
          end else if (timed_out) begin
            if (io_is_rd) begin
              D_data_in <= OPEN_BUS;
            end
            bus_err <= 1'b1;
            state   <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sms_bus_responder.sv
// Bench for sms_bus_responder: a driver task issues requests and plays the ROM
// and I/O responders; expected completions go into a scoreboard queue that an
// independent monitor drains whenever the core-side bus completes.
module tb_sms_bus_responder;

  localparam int TIMEOUT = 255;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] D_addr = 16'h0;
  logic [7:0]  D_data_out = 8'h0;
  logic [7:0]  D_data_in;
  logic        MREQ = 1'b0, IORQ = 1'b0, RD = 1'b0, WR = 1'b0;
  logic        D_wait;
  logic [21:0] rom_addr;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = 8'h0;
  logic [7:0]  io_addr, io_wdata;
  logic        io_rd, io_wr;
  logic        io_ack = 1'b0;
  logic [7:0]  io_rdata = 8'h0;
  logic        bus_err;

  sms_bus_responder #(.RAM_AW(13), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .D_addr(D_addr), .D_data_out(D_data_out),
    .D_data_in(D_data_in), .MREQ(MREQ), .IORQ(IORQ), .RD(RD), .WR(WR),
    .D_wait(D_wait), .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack),
    .rom_data(rom_data), .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd),
    .io_wr(io_wr), .io_ack(io_ack), .io_rdata(io_rdata), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         waits;
    bit         chk;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;

  // Reference state: RAM image (8KB, mirrored), sticky error, mapper banks.
  logic [7:0] mem [8192];
  bit         known [8192];
  bit         m_err = 1'b0;
  logic [7:0] banks [3];
  int         pool [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit tb_valid(input bit m, input bit i, input bit r, input bit w);
    return (int'(m) + int'(i) == 1) && (int'(r) + int'(w) == 1);
  endfunction

  function automatic logic [21:0] exp_rom(input logic [15:0] a);
`ifdef SEGA_MAPPER_EN
    if (a < 16'h0400) return {6'd0, a};
    return {banks[int'(a[15:14])], a[13:0]};
`else
    return {6'd0, a};
`endif
  endfunction

  task automatic model_reset();
    m_err = 1'b0;
    banks[0] = 8'd0;
    banks[1] = 8'd1;
    banks[2] = 8'd2;
    for (int k = 0; k < 8192; k++) known[k] = 1'b0;
  endtask

  // Monitor: counts stall cycles of the current request and checks each completion.
  int   mon_waits = 0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RST) begin
      mon_waits = 0;
    end else if (tb_valid(MREQ, IORQ, RD, WR)) begin
      if (D_wait) begin
        mon_waits++;
      end else begin
        check("sb_depth", sbq.size(), 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          check("wait_cycles", mon_waits, mon_e.waits);
          if (mon_e.chk) check("rdata", D_data_in, mon_e.data);
          check("bus_err", bus_err, mon_e.err);
        end
        mon_waits = 0;
      end
    end else begin
      mon_waits = 0;
    end
  end

  // Issue one request; lat = strobe cycle (1-based) carrying the ack, 0 = never.
  task automatic txn(input bit mreq, input bit iorq, input bit rd, input bit wr,
                     input logic [15:0] addr, input logic [7:0] wdata,
                     input int lat, input logic [7:0] rdata);
    exp_t e;
    int   n;
    int   strobes;
    bit   hs;
    bit   to;
    bit   done;
    int   idx;
    @(posedge CLK);
    #1;
    MREQ = mreq; IORQ = iorq; RD = rd; WR = wr; D_addr = addr; D_data_out = wdata;
    if (!tb_valid(mreq, iorq, rd, wr)) begin
      @(negedge CLK);
      check("nop_wait", D_wait, 0);
      check("nop_strobes", {rom_req, io_rd, io_wr}, 0);
      return;
    end
    hs = iorq || (addr < 16'hC000 && rd);
    to = hs && !(lat >= 1 && lat <= TIMEOUT);
    n  = !hs ? 0 : (to ? TIMEOUT : lat);
    if (to) m_err = 1'b1;
    e.waits = 1 + n;
    e.chk   = 1'b0;
    e.data  = 8'h00;
    if (mreq && addr >= 16'hC000) begin
      idx = int'(addr) % 8192;
      if (wr) begin
        mem[idx]   = wdata;
        known[idx] = 1'b1;
`ifdef SEGA_MAPPER_EN
        if (addr >= 16'hFFFD) banks[int'(addr) - 16'hFFFD] = wdata;
`endif
      end else begin
        e.chk  = known[idx];
        e.data = mem[idx];
      end
    end else if (hs && rd) begin
      e.chk  = 1'b1;
      e.data = to ? 8'hFF : rdata;
    end
    e.err = m_err;
    sbq.push_back(e);

    strobes = 0;
    done    = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge CLK);
      rom_ack = 1'b0;
      io_ack  = 1'b0;
      if (!D_wait) begin
        done = 1'b1;
      end else if (rom_req || io_rd || io_wr) begin
        strobes++;
        if (strobes == 1) begin
          check("strobe_kind", {rom_req, io_rd, io_wr}, iorq ? {1'b0, rd, wr} : 3'b100);
          if (iorq) begin
            check("io_addr", io_addr, addr[7:0]);
            check("io_wdata", io_wdata, wdata);
          end else begin
            check("rom_addr", rom_addr, exp_rom(addr));
          end
        end
        if (strobes == lat) begin
          rom_ack  = rom_req;
          io_ack   = io_rd | io_wr;
          rom_data = rdata;
          io_rdata = rdata;
        end
      end
    end
    if (!done) check("txn_timeout", 0, 1);
    check("strobe_cycles", strobes, n);
  endtask

  initial begin
    int         k;
    int         idx;
    logic [15:0] a;
    model_reset();
    for (int p = 0; p < 16; p++) pool[p] = $urandom_range(0, 16'h1FEF);

    #1;
    check("rst_D_wait", D_wait, 0);
    check("rst_D_data_in", D_data_in, 8'h00);
    check("rst_strobes", {rom_req, io_rd, io_wr}, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_io_wdata", io_wdata, 0);
    check("rst_bus_err", bus_err, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // RAM write/read and mirror alias
    txn(1, 0, 0, 1, 16'hC123, 8'h5A, 0, 8'h00);
    txn(1, 0, 1, 0, 16'hC123, 8'h00, 0, 8'h00);
    txn(1, 0, 1, 0, 16'hE123, 8'h00, 0, 8'h00);
    // ROM read, ack on third request cycle
    txn(1, 0, 1, 0, 16'h4000, 8'h00, 3, 8'h3C);
    // Bank-2 select then paged read
    txn(1, 0, 0, 1, 16'hFFFF, 8'h07, 0, 8'h00);
    txn(1, 0, 1, 0, 16'h8010, 8'h00, 2, 8'hA7);
    txn(1, 0, 1, 0, 16'h0123, 8'h00, 1, 8'h61);
    // I/O write and read
    txn(0, 1, 0, 1, 16'h00BE, 8'h9F, 2, 8'h00);
    txn(0, 1, 1, 0, 16'h127E, 8'h00, 1, 8'h44);
    // Malformed qualifiers are no request
    txn(1, 1, 1, 0, 16'hC123, 8'h00, 0, 8'h00);
    txn(1, 0, 1, 1, 16'hC123, 8'h11, 0, 8'h00);
    txn(0, 1, 1, 1, 16'h00BE, 8'h22, 0, 8'h00);
    txn(0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00);
    txn(1, 0, 1, 0, 16'hC123, 8'h00, 0, 8'h00);
    // ROM write is ignored
    txn(1, 0, 0, 1, 16'h1234, 8'hEE, 0, 8'h00);
    // Ack in the very last allowed cycle beats the timeout
    txn(1, 0, 1, 0, 16'h2222, 8'h00, TIMEOUT, 8'h5C);
    // I/O read with no ack: open bus and sticky error
    txn(0, 1, 1, 0, 16'h00DC, 8'h00, 0, 8'h00);

    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 9);
      if (k <= 3) begin
        idx = pool[$urandom_range(0, 15)];
        a = 16'hC000 | 16'(idx) | ($urandom_range(0, 1) == 1 ? 16'h2000 : 16'h0);
        if ($urandom_range(0, 1) == 1) txn(1, 0, 0, 1, a, 8'($urandom), 0, 8'h00);
        else                           txn(1, 0, 1, 0, a, 8'h00, 0, 8'h00);
      end else if (k <= 5) begin
        txn(1, 0, 1, 0, 16'($urandom_range(0, 16'hBFFF)), 8'h00, $urandom_range(1, 5),
            8'($urandom));
      end else if (k == 6) begin
        txn(1, 0, 0, 1, 16'($urandom_range(0, 16'hBFFF)), 8'($urandom), 0, 8'h00);
      end else if (k <= 8) begin
        if ($urandom_range(0, 1) == 1)
          txn(0, 1, 1, 0, 16'($urandom), 8'h00, $urandom_range(1, 4), 8'($urandom));
        else
          txn(0, 1, 0, 1, 16'($urandom), 8'($urandom), $urandom_range(1, 4), 8'h00);
      end else begin
        txn(0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00);
      end
    end

    // Reset in the middle of a ROM wait
    @(posedge CLK);
    #1;
    MREQ = 1; IORQ = 0; RD = 1; WR = 0; D_addr = 16'h2000;
    repeat (3) @(negedge CLK);
    check("pre_rst_rom_req", rom_req, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_drop_rom_req", rom_req, 0);
    check("rst_drop_D_wait", D_wait, 0);
    check("rst_clr_bus_err", bus_err, 0);
    MREQ = 0; RD = 0;
    sbq.delete();
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    txn(1, 0, 1, 0, 16'h3456, 8'h00, 2, 8'h9B);
    txn(1, 0, 0, 1, 16'hD000, 8'h77, 0, 8'h00);
    txn(1, 0, 1, 0, 16'hF000, 8'h00, 0, 8'h00);
    txn(0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00);

    repeat (3) @(negedge CLK);
    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
